// File: rtl/ej32_fetch.sv
// eJ32 instruction fetch / prefetch unit.
// Pulls opcode and operand bytes over a single-outstanding req/ack memory
// port into a small circular queue and presents the head byte to the
// decoder, which consumes it with p_inc. A redirect flushes the queue and
// restarts fetching at the target; a request already on the bus is allowed
// to complete and its data is thrown away.
module ej32_fetch #(
    parameter int ASZ   = 17,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    output logic           mem_req,
    output logic [ASZ-1:0] mem_a,
    input  logic           mem_ack,
    input  logic [7:0]     mem_d,
    output logic [7:0]     ib_d,
    output logic           ib_vld,
    input  logic           p_inc,
    input  logic           br_ld,
    input  logic [ASZ-1:0] br_a,
    output logic [ASZ-1:0] pc,
    output logic           stall
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // IDLE: nothing on the bus; REQ: read outstanding, data kept;
    // DROP: read outstanding, data discarded (issued before a redirect).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  rd_q, rd_d;
    logic [PW-1:0]  wr_q, wr_d;
    logic [ASZ-1:0] pc_q, pc_d;
    logic [ASZ-1:0] fa_q, fa_d;
    logic [7:0]     fifo_q [DEPTH];

    logic           push;
    logic           pop;
    logic [CW-1:0]  count_pop;   // occupancy after this cycle's pop

    assign ib_vld    = (count_q != '0);
    assign pop       = p_inc & ib_vld;
    // A redirect in the same cycle as an ack drops that byte.
    assign push      = (state_q == REQ) & mem_ack & ~br_ld;
    assign count_pop = count_q - CW'(pop);

    // Next-state, pointer and address computation; redirect wins over all.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        count_d = count_pop + CW'(push);
        rd_d    = rd_q + PW'(pop);
        wr_d    = wr_q + PW'(push);
        pc_d    = pc_q + ASZ'(pop);
        fa_d    = fa_q + ASZ'(push);

        if (br_ld) begin
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
            pc_d    = br_a;
            fa_d    = br_a;
            // A read still on the bus must finish before the new one starts.
            state_d = (state_q != IDLE && !mem_ack) ? DROP : REQ;
        end else begin
            case (state_q)
                IDLE:    if (count_pop < FULL) state_d = REQ;
                REQ:     if (mem_ack) state_d = (count_d < FULL) ? REQ : IDLE;
                DROP:    if (mem_ack) state_d = REQ;
                default: state_d = IDLE;
            endcase
        end
    end

    // Control state, pointers and addresses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            pc_q    <= '0;
            fa_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed before this edge, independent of statement order.
            state_q <= state_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            pc_q    <= pc_d;
            fa_q    <= fa_d;
        end
    end

    // Byte storage for the prefetch queue.
    // NOTE: the storage array has no reset; stale entries are never visible
    // because ib_d is forced to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q] <= mem_d;
    end

    assign mem_req = (state_q != IDLE);
    assign mem_a   = fa_q;
    assign ib_d    = ib_vld ? fifo_q[rd_q] : 8'h00;
    assign pc      = pc_q;
    assign stall   = ~ib_vld;

endmodule
